// File: rtl/concatenation_operators.sv
// Packs two equal-width operands into 2*WIDTH-bit words: {A,B}, {A,A}, {B,A} and a bit-interleave.
// Optionally registered with a one-deep valid pipeline (REG_OUT=1), else purely combinational.
module concatenation_operators #(
    parameter int WIDTH   = 4,
    parameter bit REG_OUT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 in_valid,
    output logic [2*WIDTH-1:0]   concat_result,
    output logic [2*WIDTH-1:0]   replicate_result,
    output logic [2*WIDTH-1:0]   swap_result,
    output logic [2*WIDTH-1:0]   interleave_result,
    output logic                 out_valid
);

    localparam int OW = 2 * WIDTH;

    logic [OW-1:0] concat_c;
    logic [OW-1:0] replicate_c;
    logic [OW-1:0] swap_c;
    logic [OW-1:0] interleave_c;

    always_comb begin
        concat_c     = {A, B};
        replicate_c  = {2{A}};
        swap_c       = {B, A};
        interleave_c = '0;
        // A lands on the odd bit of each pair, B on the even bit.
        for (int i = 0; i < WIDTH; i++) begin
            interleave_c[2*i+1] = A[i];
            interleave_c[2*i]   = B[i];
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [OW-1:0] concat_q,     concat_d;
            logic [OW-1:0] replicate_q,  replicate_d;
            logic [OW-1:0] swap_q,       swap_d;
            logic [OW-1:0] interleave_q, interleave_d;
            logic          valid_q,      valid_d;

            // Result registers only load on valid; otherwise they keep the last result.
            always_comb begin
                concat_d     = concat_q;
                replicate_d  = replicate_q;
                swap_d       = swap_q;
                interleave_d = interleave_q;
                valid_d      = in_valid;
                if (in_valid) begin
                    concat_d     = concat_c;
                    replicate_d  = replicate_c;
                    swap_d       = swap_c;
                    interleave_d = interleave_c;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    concat_q     <= '0;
                    replicate_q  <= '0;
                    swap_q       <= '0;
                    interleave_q <= '0;
                    valid_q      <= 1'b0;
                end else begin
                    concat_q     <= concat_d;
                    replicate_q  <= replicate_d;
                    swap_q       <= swap_d;
                    interleave_q <= interleave_d;
                    valid_q      <= valid_d;
                end
            end

            assign concat_result     = concat_q;
            assign replicate_result  = replicate_q;
            assign swap_result       = swap_q;
            assign interleave_result = interleave_q;
            assign out_valid         = valid_q;
        end else begin : g_comb
            assign concat_result     = concat_c;
            assign replicate_result  = replicate_c;
            assign swap_result       = swap_c;
            assign interleave_result = interleave_c;
            assign out_valid         = in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_concatenation_operators.sv
// Directed + random bench for concatenation_operators: registered WIDTH=4/1/8 and combinational WIDTH=4.
// Expected results come from a shift/OR reference model queued at drive time.
module tb_concatenation_operators;

    typedef struct packed {
        logic [15:0] c;
        logic [15:0] r;
        logic [15:0] s;
        logic [15:0] i;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // registered WIDTH=4
    logic [3:0] a4, b4;
    logic       v4;
    logic [7:0] r4_c, r4_r, r4_s, r4_i;
    logic       r4_v;
    // combinational WIDTH=4
    logic [3:0] ac, bc;
    logic       vc;
    logic [7:0] c4_c, c4_r, c4_s, c4_i;
    logic       c4_v;
    // registered WIDTH=1
    logic [0:0] a1, b1;
    logic       v1;
    logic [1:0] r1_c, r1_r, r1_s, r1_i;
    logic       r1_v;
    // registered WIDTH=8
    logic [7:0]  a8, b8;
    logic        v8;
    logic [15:0] r8_c, r8_r, r8_s, r8_i;
    logic        r8_v;

    concatenation_operators #(.WIDTH(4), .REG_OUT(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .in_valid(v4),
        .concat_result(r4_c), .replicate_result(r4_r), .swap_result(r4_s),
        .interleave_result(r4_i), .out_valid(r4_v));

    concatenation_operators #(.WIDTH(4), .REG_OUT(1'b0)) u_comb4 (
        .clk(clk), .rst(rst), .A(ac), .B(bc), .in_valid(vc),
        .concat_result(c4_c), .replicate_result(c4_r), .swap_result(c4_s),
        .interleave_result(c4_i), .out_valid(c4_v));

    concatenation_operators #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .in_valid(v1),
        .concat_result(r1_c), .replicate_result(r1_r), .swap_result(r1_s),
        .interleave_result(r1_i), .out_valid(r1_v));

    concatenation_operators #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .in_valid(v8),
        .concat_result(r8_c), .replicate_result(r8_r), .swap_result(r8_s),
        .interleave_result(r8_i), .out_valid(r8_v));

    int   checks = 0;
    int   errs   = 0;
    exp_t q4[$], q1[$], q8[$];
    exp_t last4, last1, last8, e;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int w);
        exp_t m;
        m.c = (16'(a) << w) | 16'(b);
        m.r = (16'(a) << w) | 16'(a);
        m.s = (16'(b) << w) | 16'(a);
        m.i = '0;
        for (int k = 0; k < w; k++) begin
            m.i[2*k+1] = a[k];
            m.i[2*k]   = b[k];
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input exp_t x, input logic v);
        chk({tag, "_concat"},     16'(r4_c), x.c);
        chk({tag, "_replicate"},  16'(r4_r), x.r);
        chk({tag, "_swap"},       16'(r4_s), x.s);
        chk({tag, "_interleave"}, 16'(r4_i), x.i);
        chk({tag, "_valid"},      16'(r4_v), 16'(v));
    endtask

    task automatic pop(inout exp_t q[$], output exp_t x, input string tag);
        if (q.size() == 0) begin
            checks++;
            errs++;
            $error("FAIL %s_underflow: observed empty queue expected entry", tag);
            x = '0;
        end else begin
            x = q.pop_front();
        end
    endtask

    task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic v, input string tag);
        a4 = a; b4 = b; v4 = v;
        if (v) q4.push_back(model(8'(a), 8'(b), 4));
        @(posedge clk);
        #1;
        if (v) pop(q4, last4, tag);
        chk4(tag, last4, v);
    endtask

    task automatic comb4(input logic [3:0] a, input logic [3:0] b, input logic v, input string tag);
        exp_t x;
        ac = a; bc = b; vc = v;
        x = model(8'(a), 8'(b), 4);
        #5;
        chk({tag, "_concat"},     16'(c4_c), x.c);
        chk({tag, "_replicate"},  16'(c4_r), x.r);
        chk({tag, "_swap"},       16'(c4_s), x.s);
        chk({tag, "_interleave"}, 16'(c4_i), x.i);
        chk({tag, "_valid"},      16'(c4_v), 16'(v));
    endtask

    initial begin
        rst = 1'b1;
        a4 = '0; b4 = '0; v4 = 1'b0;
        ac = '0; bc = '0; vc = 1'b0;
        a1 = '0; b1 = '0; v1 = 1'b0;
        a8 = '0; b8 = '0; v8 = 1'b0;
        last4 = '0; last1 = '0; last8 = '0;

        #2;
        chk4("reset", '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        step4(4'b1010, 4'b0101, 1'b1, "plan_a");
        chk("plan_a_lit_concat",     16'(r4_c), 16'b10100101);
        chk("plan_a_lit_replicate",  16'(r4_r), 16'b10101010);
        chk("plan_a_lit_swap",       16'(r4_s), 16'b01011010);
        chk("plan_a_lit_interleave", 16'(r4_i), 16'b10011001);
        step4(4'b1100, 4'b0011, 1'b1, "b2b_1");
        chk("b2b_1_lit_concat", 16'(r4_c), 16'b11000011);
        step4(4'b1111, 4'b0000, 1'b1, "b2b_2");
        chk("b2b_2_lit_concat",    16'(r4_c), 16'b11110000);
        chk("b2b_2_lit_replicate", 16'(r4_r), 16'b11111111);
        step4(4'b0001, 4'b1110, 1'b1, "b2b_3");
        chk("b2b_3_lit_replicate", 16'(r4_r), 16'b00010001);

        // hold: inputs change with in_valid low
        step4(4'b0110, 4'b1001, 1'b0, "hold_1");
        step4(4'b0011, 4'b0011, 1'b0, "hold_2");

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        last4 = '0;
        q4.delete();
        chk4("async_rst", '0, 1'b0);

        // valid input on an edge while reset is held must be ignored
        a4 = 4'b1011; b4 = 4'b0100; v4 = 1'b1;
        @(posedge clk);
        #1;
        chk4("rst_edge", '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step4(4'b1011, 4'b0100, 1'b1, "post_rst");

        // in-flight result discarded by mid-stream reset
        a4 = 4'b0111; b4 = 4'b1000; v4 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        last4 = '0;
        chk4("midstream_rst", '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        v4 = 1'b0;

        // combinational variant, clock-independent
        comb4(4'b1010, 4'b0101, 1'b1, "comb_a");
        comb4(4'b1100, 4'b0011, 1'b1, "comb_b");
        comb4(4'b1111, 4'b0000, 1'b1, "comb_c");
        comb4(4'b0001, 4'b1110, 1'b0, "comb_d");
        chk("comb_c_lit", 16'(c4_c), 16'b00011110);

        // random sweep on WIDTH=1 and WIDTH=8
        @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
            v1 = ($urandom_range(0, 3) != 0);
            v8 = ($urandom_range(0, 3) != 0);
            if (v1) q1.push_back(model(8'(a1), 8'(b1), 1));
            if (v8) q8.push_back(model(a8, b8, 8));
            @(posedge clk);
            #1;
            if (v1) pop(q1, last1, "w1");
            if (v8) pop(q8, last8, "w8");
            chk("w1_concat",     16'(r1_c), last1.c);
            chk("w1_replicate",  16'(r1_r), last1.r);
            chk("w1_swap",       16'(r1_s), last1.s);
            chk("w1_interleave", 16'(r1_i), last1.i);
            chk("w1_valid",      16'(r1_v), 16'(v1));
            chk("w8_concat",     r8_c, last8.c);
            chk("w8_replicate",  r8_r, last8.r);
            chk("w8_swap",       r8_s, last8.s);
            chk("w8_interleave", r8_i, last8.i);
            chk("w8_valid",      16'(r8_v), 16'(v8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule

// File: doc/concatenation_operators.md
Name: concatenation_operators

Overview:
- Datapath helper that builds packed words from two equal-width operands A and B using concatenation and replication.
- Outputs are the straight concatenation {A,B}, the replication {2{A}}, the swapped concatenation {B,A}, and a bit-interleave of A and B.
- Outputs are registered by default with a one-deep valid pipeline. The block sits between operand-capture logic and downstream packers and bus formatters.

Parameters:
- WIDTH, 4, operand width in bits (legal range 1 to 32). Every output is 2*WIDTH bits.
- REG_OUT, 1:
  - 1: outputs are registered, latency 1 cycle.
  - 0: outputs are purely combinational from A and B; clk and rst are unused and out_valid follows in_valid.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in_valid  input  1  qualifies A and B this cycle.
- concat_result  output  2*WIDTH  {A,B}, with A in the MSBs.
- replicate_result  output  2*WIDTH  {A,A}.
- swap_result  output  2*WIDTH  {B,A}, with B in the MSBs.
- interleave_result  output  2*WIDTH  bit 2i+1 = A[i], bit 2i = B[i], for i = 0..WIDTH-1.
- out_valid  output  1  the result outputs hold a result computed from a valid input.

Behaviour:
- All functions are pure bit rearrangement: no arithmetic, no sign handling, no X propagation beyond the inputs.
- Bit mapping, for WIDTH=4:
  - concat_result[7:4] = A, concat_result[3:0] = B.
  - replicate_result[7:4] = replicate_result[3:0] = A.
  - swap_result[7:4] = B, swap_result[3:0] = A.
- REG_OUT=1:
  - On the rising clk edge with in_valid=1, all four result registers load their functions of the current A and B, and out_valid is set to 1.
  - On a rising edge with in_valid=0, the result registers hold their previous values and out_valid is set to 0.
  - Latency is exactly 1 cycle from the sampling edge. Back-to-back valid inputs give back-to-back valid outputs; there is no stall or backpressure.
- Reset (REG_OUT=1):
  - While rst=1, every result output is 0 and out_valid is 0, regardless of clk.
  - Assertion takes effect immediately, including mid-stream; any in-flight result is discarded.
  - On the first rising edge after rst deasserts, the block samples normally.
  - If rst and a clock edge coincide, reset wins.
- REG_OUT=0:
  - Outputs update combinationally whenever A or B change.
  - out_valid = in_valid. rst and clk have no effect.
- Boundary cases:
  - All-zero and all-one operands map straight through; for example A=1111, B=0000 gives concat 11110000.
  - WIDTH=1: concat = {A,B}, replicate = {A,A}, interleave = {A,B}.

Test Plan:
- Reset: assert rst asynchronously between clock edges -> all outputs go to 0 and out_valid goes to 0 without waiting for a clock edge.
- REG_OUT=1, WIDTH=4, apply A=1010, B=0101, in_valid=1 for one edge -> on the next cycle:
  - concat=10100101, replicate=10101010, swap=01011010, interleave=10011001, out_valid=1.
- Back-to-back valid operands, each sampled one cycle before its result appears:
  - A=1100, B=0011 -> concat=11000011, replicate=11001100.
  - Then A=1111, B=0000 -> concat=11110000, replicate=11111111.
  - Then A=0001, B=1110 -> concat=00011110, replicate=00010001.
- Hold: drop in_valid while changing A and B -> outputs keep their last values and out_valid=0. Then assert rst mid-hold -> all outputs clear.
- REG_OUT=0: apply the same four vectors, 5 time units apart and with no clock -> each output matches its function combinationally within the same timestep.
- WIDTH=1 and WIDTH=8 random sweep -> every output matches its bit-mapping formula against a reference model, 1000 vectors each.
